// File: rtl/scan_capture.sv
// scan_capture: serial frame receiver sharing a frame strobe with a scan transmitter.
// A 0->1 edge on en starts a frame; WIDTH bits are then taken from scan_in, LSB first,
// one per cycle. The completed frame is published on data with a one-cycle valid pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         frame strobe; only its rising edge matters
//   scan_in    serial data, LSB first
//   abort_clr  clears the sticky aborted flag
//   data       last completely received frame
//   valid      one-cycle pulse when data updates
//   busy       high while a frame is being shifted in
//   aborted    sticky: a frame was restarted before completion
//   frame_cnt  completed frame count, wrapping
//
// state | meaning
// IDLE  | waiting for a rising edge on en; scan_in ignored
// SHIFT | sampling bit bit_idx from scan_in each cycle
module scan_capture #(
  parameter int WIDTH = 19,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             scan_in,
  input  logic             abort_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             aborted,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             last_en_q, last_en_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             start;
  logic             last_bit;
  logic [WIDTH-1:0] sr_ins;

  always_comb begin
    start     = en & ~last_en_q;
    last_bit  = (state_q == SHIFT) && (bit_idx_q == LAST_IDX);
    sr_ins    = sr_q;
    sr_ins[bit_idx_q] = scan_in;

    last_en_d = en;
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    aborted_d = aborted_q;
    cnt_d     = cnt_q;

    if (abort_clr) aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bit_idx_d = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // The final bit completes the frame even when a new start
          // arrives in the same cycle; that start just chains the next frame.
          sr_d      = sr_ins;
          data_d    = sr_ins;
          valid_d   = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          bit_idx_d = '0;
          state_d   = start ? SHIFT : IDLE;
        end else if (start) begin
          // Restart mid-frame: partial bits are simply overwritten by the new frame.
          bit_idx_d = '0;
          aborted_d = 1'b1;
        end else begin
          sr_d      = sr_ins;
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_en_q <= 1'b0;
      bit_idx_q <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_en_q <= last_en_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SHIFT);
  assign aborted   = aborted_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_scan_capture.sv
// Bench for scan_capture: frame-level stimulus, scoreboard of expected frames,
// and a monitor that checks valid timing, data, frame_cnt, busy and data hold.
module tb_scan_capture;
  localparam int W  = 19;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n, en, scan_in, abort_clr;
  logic [W-1:0]  data;
  logic          valid, busy, aborted;
  logic [CW-1:0] frame_cnt;

  scan_capture #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .scan_in(scan_in), .abort_clr(abort_clr),
    .data(data), .valid(valid), .busy(busy), .aborted(aborted), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    int            edge_no;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            edge_n   = 0;
  int            busy_from = 0;
  int            busy_to   = 0;
  logic [CW-1:0] cnt_model = '0;
  logic          exp_aborted = 1'b0;
  logic [W-1:0]  hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic rst_s;
    exp_t e;
    rst_s = rst_n;
    edge_n++;
    #1;
    if (!rst_s) begin
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      hold = '0;
    end else begin
      check("busy", 32'(busy), 32'(edge_n >= busy_from && edge_n < busy_to));
      while (sb.size() > 0 && sb[0].edge_no < edge_n) begin
        e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_valid: got none expected frame %0h at edge %0d", e.d, e.edge_no);
      end
      if (valid) begin
        if (sb.size() == 0 || sb[0].edge_no != edge_n) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid with data %0h at edge %0d expected none", data, edge_n);
          hold = data;
        end else begin
          e = sb.pop_front();
          check("frame_data", 32'(data), 32'(e.d));
          check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
          hold = e.d;
        end
      end else begin
        check("data_hold", 32'(data), 32'(hold));
      end
    end
  end

  // One frame: cycle 0 raises en, then nbits data cycles. c0 < 0 drives a random
  // bit in cycle 0, otherwise that value (the previous frame's last bit when chaining).
  task automatic frame(input logic [W-1:0] d, input int nbits, input bit complete,
                       input bit en_hold, input int c0, input bit clr0);
    int k;
    int s;
    @(negedge clk);
    k = edge_n;
    s = k + 1;
    rst_n     = 1'b1;
    en        = 1'b1;
    abort_clr = clr0;
    scan_in   = (c0 < 0) ? 1'($urandom_range(0, 1)) : c0[0];
    if (k >= busy_from && k < busy_to - 1) exp_aborted = 1'b1;
    else if (clr0) exp_aborted = 1'b0;
    busy_from = s;
    busy_to   = s + W;
    if (complete) begin
      cnt_model = cnt_model + 1'b1;
      sb.push_back('{d, s + W, cnt_model});
    end
    for (int j = 0; j < nbits; j++) begin
      @(negedge clk);
      en        = en_hold;
      abort_clr = 1'b0;
      scan_in   = d[j];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en        = 1'b0;
      abort_clr = 1'b0;
      scan_in   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_abort();
    @(negedge clk);
    en        = 1'b0;
    abort_clr = 1'b1;
    exp_aborted = 1'b0;
    @(negedge clk);
    abort_clr = 1'b0;
  endtask

  task automatic do_reset(input int n, input bit en_level);
    @(negedge clk);
    rst_n = 1'b0;
    en    = en_level;
    busy_to = 0;
    cnt_model = '0;
    exp_aborted = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d1, d2;
    int pending;
    rst_n = 1'b0; en = 1'b0; scan_in = 1'b0; abort_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Known vector, then all-ones (en held high) and 1 back to back.
    frame(19'h5A3C1, W, 1, 0, -1, 0);
    idle(3);
    check("cnt_after_first", 32'(frame_cnt), 32'd1);
    frame(19'h7FFFF, W, 1, 1, -1, 0);
    idle(1);
    frame(19'h00001, W, 1, 0, -1, 0);
    idle(3);
    check("aborted_clean", 32'(aborted), 32'(exp_aborted));

    // Restart at cycle 10 aborts the first frame; the second completes.
    d1 = W'($urandom); d2 = W'($urandom);
    frame(d1, 9, 0, 0, -1, 0);
    frame(d2, W, 1, 0, -1, 0);
    idle(3);
    check("aborted_set", 32'(aborted), 32'(exp_aborted));
    clear_abort();
    idle(1);
    check("aborted_cleared", 32'(aborted), 32'(exp_aborted));

    // Restart coinciding with abort_clr: set wins.
    frame(W'($urandom), 5, 0, 0, -1, 0);
    frame(W'($urandom), 5, 0, 0, -1, 1);
    frame(W'($urandom), W, 1, 0, -1, 0);
    idle(3);
    check("abort_set_wins", 32'(aborted), 32'(exp_aborted));
    clear_abort();

    // Restart in the final cycle chains frames without aborting.
    d1 = W'($urandom); d2 = W'($urandom);
    frame(d1, W - 1, 1, 0, -1, 0);
    frame(d2, W, 1, 0, int'(d1[W-1]), 0);
    idle(3);
    check("aborted_chain", 32'(aborted), 32'(exp_aborted));

    // Reset at cycle 8 of a frame with en held high through release.
    frame(W'($urandom), 7, 0, 0, -1, 0);
    do_reset(3, 1'b1);
    frame(W'($urandom), W, 1, 0, -1, 0);
    idle(3);

    // 256 frames from reset, randomly chained or separated: counter wraps to 0.
    do_reset(2, 1'b0);
    idle(1);
    pending = -1;
    for (int i = 0; i < 256; i++) begin
      bit ov;
      d1 = W'($urandom);
      ov = 1'($urandom_range(0, 1));
      frame(d1, ov ? W - 1 : W, 1, 0, pending, 0);
      pending = ov ? int'(d1[W-1]) : -1;
    end
    if (pending >= 0) begin
      @(negedge clk);
      en = 1'b0;
      scan_in = pending[0];
    end
    idle(W + 3);
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("aborted_final", 32'(aborted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_capture.md
SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: the clock is named clk and the reset is named rst_n.
REQ-002 The block SHALL have parameter WIDTH, default 19, giving the number of bits per frame.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the frame counter.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: frame strobe shared with the scan transmitter; a 0->1 transition starts a frame.
REQ-007 The block SHALL have port scan_in, input, 1 bit: serial data, LSB first.
REQ-008 The block SHALL have port data, output, WIDTH bits: the last completely received frame.
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse when data updates.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is being shifted in.
REQ-011 The block SHALL have port aborted, output, 1 bit: sticky flag set when a frame is restarted before it completes.
REQ-012 The block SHALL have port abort_clr, input, 1 bit: clears aborted.
REQ-013 The block SHALL have port frame_cnt, output, CNT_W bits: count of completed frames, wrapping.

Function
REQ-014 The block SHALL register en into last_en every cycle; start = en & !last_en.
REQ-015 The block SHALL use a 2-state FSM, IDLE and SHIFT, plus a bit counter bit_idx of width clog2(WIDTH).
REQ-016 The cycle in which start is high is cycle 0; at the edge ending cycle 0 the FSM SHALL go to SHIFT with bit_idx = 0 and shift register sr unchanged.
REQ-017 Bit k (k = 0..WIDTH-1) SHALL be sampled from scan_in at the edge ending cycle k+1, i.e. written into sr[k] (LSB first); bit_idx then increments.
REQ-018 At the edge ending cycle WIDTH (bit_idx = WIDTH-1): data SHALL get sr with bit WIDTH-1 = scan_in; frame_cnt SHALL increment, wrapping modulo 2^CNT_W; the FSM SHALL return to IDLE.
REQ-019 valid SHALL be high only during cycle WIDTH+1 (latency of WIDTH+1 cycles from start); data SHALL be stable at all other times.
REQ-020 busy SHALL equal (state == SHIFT), high during cycles 1..WIDTH.
REQ-021 Level of en after start SHALL be ignored: en may fall or stay high mid-frame without effect.
REQ-022 A start in SHIFT (restart) SHALL reset bit_idx to 0, stay in SHIFT, discard the partial frame, not update data or frame_cnt, and set aborted.
REQ-023 A start in the final cycle (bit_idx = WIDTH-1) SHALL complete the frame (data, valid, frame_cnt as in REQ-018), SHALL begin a new frame with bit_idx = 0 in SHIFT, and SHALL NOT set aborted.
REQ-024 If abort_clr and an abort-setting restart occur in the same cycle, set SHALL win.
REQ-025 In IDLE with no start, scan_in SHALL be ignored.

Reset
REQ-026 While rst_n = 0 at a clock edge, the block SHALL set: state IDLE, last_en 0, bit_idx 0, sr 0, data 0, valid 0, busy 0, aborted 0, frame_cnt 0.
REQ-027 Reset SHALL take priority over every other event, including a mid-frame reset, which discards the partial frame with no valid pulse.
REQ-028 Because last_en = 0 after reset, en held high at reset release SHALL produce a start in the first cycle out of reset.

Verification
REQ-029 Pulse en at cycle 0, drive scan_in with the bits of 19'h5A3C1 LSB first in cycles 1..19 -> valid high only in cycle 20, data = 19'h5A3C1, frame_cnt = 1, busy high in cycles 1..19 only.
REQ-030 Connect the bench to the scan transmitter (both its variants) with shared en and scan_data = 19'h7FFFF, then 19'h00001 -> data matches each, valid pulses twice, aborted = 0.
REQ-031 Restart en at cycle 10 of a frame -> no valid at cycle 20, aborted = 1; the new frame completes 20 cycles after the restart; abort_clr -> aborted = 0.
REQ-032 Restart at cycle 19 -> frame 1 is delivered (valid in cycle 20), frame 2 is delivered 20 cycles later, aborted = 0.
REQ-033 Assert rst_n low at cycle 8 of a frame -> all outputs 0, no valid; with en held high through reset release, a frame starts in the first cycle.
REQ-034 Run 256 back-to-back frames with CNT_W = 8 -> frame_cnt wraps to 0, each data value is correct.
